// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for a stable lock, then
// releases the downstream system reset and watches for lock loss afterwards.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int CNT_W = 20;

    // Terminal counts: each state leaves on the cycle its counter equals N-1,
    // so the counter can never pass its largest terminal value.
    localparam logic [CNT_W-1:0] PLL_RST_TC = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_TC    = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             sync1_reg;
    logic             lock_s_reg;
    logic             pll_rst_reg;
    logic             sys_rst_reg;
    logic             ready_reg;
    logic [7:0]       relock_count_reg;
    logic             timeout_err_reg;
    logic             timeout_set;
    logic             relock_inc;

    always_comb begin
        state_next  = state_reg;
        timeout_set = 1'b0;
        relock_inc  = 1'b0;
        // Lock loss is tested before every terminal count so it always wins.
        case (state_reg)
            PLL_RESET: begin
                if (cnt_reg == PLL_RST_TC) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s_reg) begin
                    state_next = STABLE;
                end else if (cnt_reg == LOCK_TC) begin
                    state_next  = PLL_RESET;
                    timeout_set = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s_reg)                state_next = WAIT_LOCK;
                else if (cnt_reg == STABLE_TC)  state_next = HOLD;
            end
            HOLD: begin
                if (!lock_s_reg)                state_next = PLL_RESET;
                else if (cnt_reg == HOLD_TC)    state_next = RUN;
            end
            RUN: begin
                if (!lock_s_reg) begin
                    state_next = PLL_RESET;
                    relock_inc = 1'b1;
                end
            end
            default: state_next = PLL_RESET;
        endcase

        // RUN has no terminal count, so the counter is frozen there.
        if (state_next != state_reg)  cnt_next = '0;
        else if (state_reg == RUN)    cnt_next = cnt_reg;
        else                          cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg        <= PLL_RESET;
            cnt_reg          <= '0;
            sync1_reg        <= 1'b0;
            lock_s_reg       <= 1'b0;
            pll_rst_reg      <= 1'b1;
            sys_rst_reg      <= 1'b1;
            ready_reg        <= 1'b0;
            relock_count_reg <= 8'd0;
            timeout_err_reg  <= 1'b0;
        end else begin
            sync1_reg  <= locked;
            lock_s_reg <= sync1_reg;
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            // Outputs decode the next state so they switch on the transition edge.
            pll_rst_reg <= (state_next == PLL_RESET);
            sys_rst_reg <= (state_next != RUN);
            ready_reg   <= (state_next == RUN);
            if (relock_inc && (relock_count_reg != 8'hFF))
                relock_count_reg <= relock_count_reg + 8'd1;
            if (timeout_set)
                timeout_err_reg <= 1'b1;
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign sys_rst      = sys_rst_reg;
    assign ready        = ready_reg;
    assign relock_count = relock_count_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, meaning refclk cycles pll_rst is held per PLL reset pulse (range 1..65535).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, meaning consecutive cycles synchronized locked must stay high before lock is accepted (range 1..65535).
REQ-003 SHALL have parameter HOLD_CYCLES, default 64, meaning cycles sys_rst is held after lock is accepted (range 1..65535).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65536, meaning maximum cycles spent in WAIT_LOCK before the PLL is reset again (range 1..2^20).
REQ-005 SHALL have port refclk, input, 1 bit: the only clock, the free-running board reference clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port locked, input, 1 bit: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1 bit: registered active-high reset to the PLL.
REQ-009 SHALL have port sys_rst, output, 1 bit: registered active-high reset for logic on the PLL output clock.
REQ-010 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port relock_count, output, 8 bits: number of lock losses seen in RUN.
REQ-012 SHALL have port timeout_err, output, 1 bit: sticky lock-timeout flag.

Function
REQ-013 SHALL pass locked through a 2-flop synchronizer clocked by refclk; lock_s is the second flop; all decisions use lock_s only.
REQ-014 SHALL implement states PLL_RESET, WAIT_LOCK, STABLE, HOLD and RUN, with one shared cycle counter cleared on every state entry.
REQ-015 PLL_RESET: pll_rst=1, sys_rst=1; after PLL_RST_CYCLES cycles in the state, go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0, sys_rst=1; when lock_s=1, go to STABLE; when LOCK_TIMEOUT cycles elapse without lock, set timeout_err and go to PLL_RESET.
REQ-017 STABLE: sys_rst=1; when lock_s=0, go to WAIT_LOCK, which clears the counter but does not reset the timeout history; after STABLE_CYCLES consecutive high cycles, go to HOLD.
REQ-018 HOLD: sys_rst=1; when lock_s=0, go to PLL_RESET; after HOLD_CYCLES cycles, go to RUN.
REQ-019 RUN: sys_rst=0, ready=1; when lock_s=0, go to PLL_RESET and increment relock_count.
REQ-020 In RUN, sys_rst and ready SHALL change on the same edge that registers the transition: 1 and 0 respectively, one cycle after lock_s falls.
REQ-021 relock_count SHALL saturate at 255 and never wrap.
REQ-022 timeout_err SHALL stay set until rst; a later successful lock does not clear it.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from locked to any output.
REQ-024 When lock_s falls on the same cycle a state's counter reaches terminal count, the lock-loss transition SHALL take priority.
REQ-025 Output timing: sys_rst falls exactly 2 + STABLE_CYCLES + HOLD_CYCLES cycles after the locked edge, within one cycle of locked synchronizer uncertainty.
REQ-026 The counter SHALL be 20 bits wide and SHALL never overflow, because every state exits at or before its terminal count.

Reset
REQ-027 Asserting rst SHALL immediately, asynchronously, force state=PLL_RESET, pll_rst=1, sys_rst=1, ready=0, relock_count=0, timeout_err=0, counter=0 and synchronizer flops=0.
REQ-028 Asserting rst in any state, including RUN, SHALL abort the current sequence with no glitch on sys_rst.
REQ-029 After rst falls, the PLL_RESET count SHALL start on the first refclk edge.

Verification (PLL_RST_CYCLES=4, STABLE_CYCLES=8, HOLD_CYCLES=4, LOCK_TIMEOUT=32)
REQ-030 Bench SHALL cover power-up: release rst, raise locked at cycle 10 -> pll_rst high for cycles 1-4; sys_rst falls and ready rises 2+8+4=14 cycles after locked is sampled; relock_count=0.
REQ-031 Bench SHALL cover a lock glitch in STABLE: locked high for 5 cycles, low for 1, then high -> return to WAIT_LOCK; the full 8-cycle stable count restarts; sys_rst is never released early.
REQ-032 Bench SHALL cover timeout: locked held low -> after 32 WAIT_LOCK cycles timeout_err=1 and pll_rst pulses high for 4 cycles; the pattern repeats; timeout_err stays 1 after a later lock.
REQ-033 Bench SHALL cover lock loss in RUN: locked drops -> sys_rst=1 and ready=0 3 cycles after the locked edge, relock_count goes 0->1, pll_rst pulses, and recovery proceeds as in power-up.
REQ-034 Bench SHALL cover saturation: 260 lock losses in RUN -> relock_count=255.
REQ-035 Bench SHALL cover async reset: rst pulse mid-HOLD between clock edges -> all outputs take reset values before the next edge.
